timer_core: RTL and testbench
=============================

# timer_core

Synchronous, parametrised mm:ss timer core that replaces the rippled per-digit counter chain in the board top level. It counts down to 00:00 or up to a configurable maximum, generates its own tick from MCLK, accepts set/start/clear commands as single-cycle pulses, and raises an alarm on expiry. It sits between the button debouncers/edge detectors and the four bcd_to_7seg display decoders.

## Interface
- TICK_CYCLES, 25175000, MCLK cycles per timer step (1 s at the 25.175 MHz board clock); must be ≥ 2.
- MAX_MIN, 99, highest minute value (1..99); sets the wrap and count-up limit.
- ALARM_TICKS, 10, number of ticks the ALARM output stays high (≥ 1).

- MCLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- START_STOP  in  1  one-cycle pulse: start, or pause a running timer.
- ADD_SEC  in  1  one-cycle pulse: +1 s while stopped.
- ADD_MIN  in  1  one-cycle pulse: +1 min while stopped.
- CLEAR  in  1  one-cycle pulse: value to 00:00 and state to IDLE.
- MODE_UP  in  1  level input: 1 = count up, 0 = count down; sampled only on start.
- MIN_1, MIN_0, SEC_1, SEC_0  out  4 each  BCD digits of the current value.
- RUNNING  out  1  high in RUN.
- ALARM  out  1  high in ALARM.
- TICK  out  1  one-cycle pulse on each prescaler wrap.

## Operation
- States: IDLE (stopped, editable), RUN, ALARM.
- Reset: all digits 0, RUNNING=0, ALARM=0, TICK=0, prescaler=0, mode latch=down, state IDLE.
- Command priority in the same cycle: CLEAR > START_STOP > ADD_MIN > ADD_SEC. Only the highest-priority pulse is acted on.
- IDLE:
  - ADD_SEC: +1 s with carry; SEC 59→00 and MIN+1.
  - At MAX_MIN:59, ADD_SEC wraps to 00:00.
  - ADD_MIN: MIN+1, wrapping MAX_MIN→00. SEC is unchanged.
  - START_STOP: latch MODE_UP, clear the prescaler, go to RUN.
  - START_STOP is ignored (stay IDLE) when down mode is selected with value 00:00, or up mode with value MAX_MIN:59.
- RUN:
  - The prescaler counts 0..TICK_CYCLES-1. On the wrap it pulses TICK and steps the value by ±1 s with BCD borrow/carry across all four digits.
  - Down-count reaching 00:00 goes to ALARM on the same edge.
  - Up-count reaching MAX_MIN:59 goes to ALARM on the same edge; the value holds at the limit.
  - START_STOP: go to IDLE (pause). The value is kept; the prescaler is cleared on the next start.
  - ADD_SEC and ADD_MIN are ignored. MODE_UP changes are ignored.
- ALARM:
  - The prescaler keeps running and TICK keeps pulsing; the value is frozen.
  - After ALARM_TICKS ticks, go to IDLE.
  - Any START_STOP, ADD_SEC or ADD_MIN pulse acknowledges the alarm: go to IDLE, and the pulse has no other effect.
  - CLEAR goes to IDLE and sets 00:00.
- Digit invariants: SEC_1 ≤ 5, SEC_0 ≤ 9, MIN_0 ≤ 9, and the value is always ≤ MAX_MIN:59. Digits never hold a non-BCD code.

## Timing
- All outputs are registered. A command pulse sampled at edge k is visible on the outputs after edge k.
- Start sampled at edge k: RUNNING=1 after k; the first TICK and value step occur after edge k+TICK_CYCLES, then every TICK_CYCLES cycles.
- TICK is high for exactly one cycle, coincident with the value update it causes.
- Expiry: the final step and the ALARM rise (with the RUNNING fall) happen on the same edge.
- ALARM auto-clears on the edge of the ALARM_TICKS-th TICK after entry.
- RST_N low at any edge, in any state and mid-tick, forces the reset values after that edge. Commands in that cycle are discarded.

## Test plan
- Set and wrap: TICK_CYCLES=4, MAX_MIN=99. From reset, 3×ADD_MIN then 61×ADD_SEC → 04:01. Then 96×ADD_MIN → 00:01.
- Countdown expiry: 00:03, down mode, START at edge k → values 00:02/00:01/00:00 after k+4/k+8/k+12. ALARM=1 and RUNNING=0 after k+12. ALARM=0 after k+12+4·ALARM_TICKS.
- Pause/resume: run from 01:00, START_STOP at edge k+6 → 00:59 held, RUNNING=0. ADD_SEC → 01:00. START again → next step exactly 4 cycles later.
- Count-up limit: MAX_MIN=2, value 02:58, up mode, START → 02:59 after 4 cycles, ALARM=1 on the same edge, value holds. ADD_SEC during ALARM → IDLE with 02:59.
- Priority and ignores: CLEAR+START_STOP in the same cycle → 00:00, IDLE. START at 00:00 in down mode → RUNNING stays 0.
- Reset mid-run: RST_N=0 for one cycle two cycles before a tick → all outputs zero, IDLE. No TICK appears 2 cycles later.

Source files
------------

// File: rtl/timer_core.sv
// rtl/timer_core.sv - BCD mm:ss up/down timer with internal tick prescaler and alarm
module timer_core #(
  parameter int TICK_CYCLES = 25175000,
  parameter int MAX_MIN     = 99,
  parameter int ALARM_TICKS = 10
) (
  input  logic       MCLK,
  input  logic       RST_N,
  input  logic       START_STOP,
  input  logic       ADD_SEC,
  input  logic       ADD_MIN,
  input  logic       CLEAR,
  input  logic       MODE_UP,
  output logic [3:0] MIN_1,
  output logic [3:0] MIN_0,
  output logic [3:0] SEC_1,
  output logic [3:0] SEC_0,
  output logic       RUNNING,
  output logic       ALARM,
  output logic       TICK
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam int AW = $clog2(ALARM_TICKS + 1);
  localparam logic [3:0]  MAX_M1  = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MAX_M0  = 4'(MAX_MIN % 10);
  localparam logic [15:0] MAX_VAL = {MAX_M1, MAX_M0, 4'd5, 4'd9};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ALARM} state_t;

  state_t          state_q, state_d;
  logic [15:0]     val_q, val_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [AW-1:0]   alm_q, alm_d;
  logic            mode_q, mode_d;
  logic            tick_q, tick_d;
  logic            running_q, alarm_q;
  logic            wrap;
  logic [15:0]     step;
  logic [15:0]     limit;

  // Minute increment wraps MAX_MIN back to 00.
  function automatic logic [7:0] min_inc(input logic [7:0] m);
    logic [3:0] m1, m0;
    {m1, m0} = m;
    if (m1 == MAX_M1 && m0 == MAX_M0) begin
      m1 = 4'd0;
      m0 = 4'd0;
    end else if (m0 != 4'd9) begin
      m0 = m0 + 4'd1;
    end else begin
      m0 = 4'd0;
      m1 = m1 + 4'd1;
    end
    return {m1, m0};
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] s1, s0;
    logic [7:0] m;
    {m, s1, s0} = v;
    if (v == MAX_VAL) return 16'h0000;
    if (s0 != 4'd9) begin
      s0 = s0 + 4'd1;
    end else begin
      s0 = 4'd0;
      if (s1 != 4'd5) begin
        s1 = s1 + 4'd1;
      end else begin
        s1 = 4'd0;
        m  = min_inc(m);
      end
    end
    return {m, s1, s0};
  endfunction

  // Only called from nonzero values; the RUN state never steps down from 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = v;
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = 4'd5;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    presc_d = presc_q;
    alm_d   = alm_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    wrap    = (presc_q == PW'(TICK_CYCLES - 1));
    step    = mode_q ? bcd_inc(val_q) : bcd_dec(val_q);
    limit   = mode_q ? MAX_VAL : 16'h0000;
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (CLEAR) begin
          val_d = 16'h0000;
        end else if (START_STOP) begin
          if (!(MODE_UP ? (val_q == MAX_VAL) : (val_q == 16'h0000))) begin
            mode_d  = MODE_UP;
            state_d = S_RUN;
          end
        end else if (ADD_MIN) begin
          val_d = {min_inc(val_q[15:8]), val_q[7:0]};
        end else if (ADD_SEC) begin
          val_d = bcd_inc(val_q);
        end
      end
      S_RUN: begin
        presc_d = wrap ? '0 : presc_q + PW'(1);
        if (CLEAR) begin
          state_d = S_IDLE;
          val_d   = 16'h0000;
        end else if (START_STOP) begin
          state_d = S_IDLE;
        end else if (wrap) begin
          tick_d = 1'b1;
          val_d  = step;
          if (step == limit) begin
            state_d = S_ALARM;
            alm_d   = '0;
          end
        end
      end
      S_ALARM: begin
        presc_d = wrap ? '0 : presc_q + PW'(1);
        if (CLEAR) begin
          state_d = S_IDLE;
          val_d   = 16'h0000;
        end else if (START_STOP || ADD_SEC || ADD_MIN) begin
          state_d = S_IDLE;
        end else if (wrap) begin
          tick_d = 1'b1;
          if (alm_q == AW'(ALARM_TICKS - 1)) state_d = S_IDLE;
          else                               alm_d   = alm_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      val_q     <= 16'h0000;
      presc_q   <= '0;
      alm_q     <= '0;
      mode_q    <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      presc_q   <= presc_d;
      alm_q     <= alm_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      running_q <= (state_d == S_RUN);
      alarm_q   <= (state_d == S_ALARM);
    end
  end

  assign {MIN_1, MIN_0, SEC_1, SEC_0} = val_q;
  assign RUNNING = running_q;
  assign ALARM   = alarm_q;
  assign TICK    = tick_q;

endmodule

// File: tb/tb_timer_core.sv
// tb/tb_timer_core.sv - directed self-checking bench for timer_core
module tb_timer_core;

  logic clk = 1'b0;
  logic rst_n, start_stop, add_sec, add_min, clear, mode_up;
  logic [3:0] a_m1, a_m0, a_s1, a_s0, b_m1, b_m0, b_s1, b_s0;
  logic a_run, a_alm, a_tick, b_run, b_alm, b_tick;
  logic [15:0] a_val, b_val;
  int checks = 0;
  int errors = 0;

  assign a_val = {a_m1, a_m0, a_s1, a_s0};
  assign b_val = {b_m1, b_m0, b_s1, b_s0};

  always #5 clk = ~clk;

  timer_core #(.TICK_CYCLES(4), .MAX_MIN(99), .ALARM_TICKS(3)) dut_a (
    .MCLK(clk), .RST_N(rst_n), .START_STOP(start_stop), .ADD_SEC(add_sec),
    .ADD_MIN(add_min), .CLEAR(clear), .MODE_UP(mode_up),
    .MIN_1(a_m1), .MIN_0(a_m0), .SEC_1(a_s1), .SEC_0(a_s0),
    .RUNNING(a_run), .ALARM(a_alm), .TICK(a_tick));

  timer_core #(.TICK_CYCLES(4), .MAX_MIN(2), .ALARM_TICKS(3)) dut_b (
    .MCLK(clk), .RST_N(rst_n), .START_STOP(start_stop), .ADD_SEC(add_sec),
    .ADD_MIN(add_min), .CLEAR(clear), .MODE_UP(mode_up),
    .MIN_1(b_m1), .MIN_0(b_m0), .SEC_1(b_s1), .SEC_0(b_s0),
    .RUNNING(b_run), .ALARM(b_alm), .TICK(b_tick));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // bits: {clear, start_stop, add_min, add_sec}; driven for one edge, returns at the next negedge
  task automatic cmd(input logic [3:0] c, input int n = 1);
    for (int i = 0; i < n; i++) begin
      {clear, start_stop, add_min, add_sec} = c;
      @(negedge clk);
      {clear, start_stop, add_min, add_sec} = 4'b0000;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam logic [3:0] C_CLR = 4'b1000, C_SS = 4'b0100, C_MIN = 4'b0010, C_SEC = 4'b0001;

  initial begin
    rst_n = 1'b0; mode_up = 1'b0;
    {clear, start_stop, add_min, add_sec} = 4'b0000;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("reset_val", a_val, 16'h0000);
    chk("reset_flags", {13'd0, a_run, a_alm, a_tick}, 16'h0000);

    // set and wrap
    cmd(C_MIN, 3);
    chk("add_min3", a_val, 16'h0300);
    cmd(C_SEC, 61);
    chk("add_sec61", a_val, 16'h0401);
    cmd(C_MIN, 96);
    chk("min_wrap", a_val, 16'h0001);

    // countdown expiry
    cmd(C_CLR);
    cmd(C_SEC, 3);
    cmd(C_SS);
    chk("cd_running", {15'd0, a_run}, 16'd1);
    idle(3);
    chk("cd_k3_val", a_val, 16'h0003);
    chk("cd_k3_tick", {15'd0, a_tick}, 16'd0);
    idle(1);
    chk("cd_k4_val", a_val, 16'h0002);
    chk("cd_k4_tick", {15'd0, a_tick}, 16'd1);
    idle(1);
    chk("cd_k5_tick", {15'd0, a_tick}, 16'd0);
    idle(3);
    chk("cd_k8_val", a_val, 16'h0001);
    idle(4);
    chk("cd_k12_val", a_val, 16'h0000);
    chk("cd_k12_flags", {14'd0, a_run, a_alm}, 16'b01);
    idle(11);
    chk("cd_k23_alarm", {15'd0, a_alm}, 16'd1);
    idle(1);
    chk("cd_k24_alarm", {15'd0, a_alm}, 16'd0);

    // pause / resume
    cmd(C_CLR);
    cmd(C_MIN);
    cmd(C_SS);
    idle(5);
    cmd(C_SS);
    chk("pause_val", a_val, 16'h0059);
    chk("pause_run", {15'd0, a_run}, 16'd0);
    idle(4);
    chk("pause_hold", a_val, 16'h0059);
    cmd(C_SEC);
    chk("pause_addsec", a_val, 16'h0100);
    cmd(C_SS);
    idle(3);
    chk("resume_k3", a_val, 16'h0100);
    idle(1);
    chk("resume_k4", a_val, 16'h0059);
    chk("resume_tick", {15'd0, a_tick}, 16'd1);

    // count-up limit on the MAX_MIN=2 instance
    cmd(C_CLR);
    cmd(C_MIN, 2);
    cmd(C_SEC, 58);
    chk("up_set", b_val, 16'h0258);
    mode_up = 1'b1;
    cmd(C_SS);
    mode_up = 1'b0;
    chk("up_running", {15'd0, b_run}, 16'd1);
    idle(3);
    chk("up_k3", b_val, 16'h0258);
    idle(1);
    chk("up_k4_val", b_val, 16'h0259);
    chk("up_k4_flags", {14'd0, b_run, b_alm}, 16'b01);
    idle(4);
    chk("up_hold", b_val, 16'h0259);
    chk("up_alarm_on", {15'd0, b_alm}, 16'd1);
    cmd(C_SEC);
    chk("up_ack_alarm", {14'd0, b_run, b_alm}, 16'b00);
    chk("up_ack_val", b_val, 16'h0259);
    cmd(C_SEC);
    chk("b_sec_wrap", b_val, 16'h0000);

    // priority and ignores
    cmd(C_CLR);
    cmd(C_SEC);
    cmd(C_CLR | C_SS);
    chk("prio_clr_val", a_val, 16'h0000);
    chk("prio_clr_run", {15'd0, a_run}, 16'd0);
    cmd(C_SS);
    chk("start_zero_ign", {15'd0, a_run}, 16'd0);
    cmd(C_MIN | C_SEC);
    chk("prio_min_sec", a_val, 16'h0100);

    // reset mid-run
    cmd(C_CLR);
    cmd(C_SEC, 5);
    cmd(C_SS);
    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_val", a_val, 16'h0000);
    chk("rst_flags", {13'd0, a_run, a_alm, a_tick}, 16'h0000);
    idle(2);
    chk("rst_no_tick", {13'd0, a_run, a_alm, a_tick}, 16'h0000);
    chk("rst_val_hold", a_val, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
